// File: rtl/param_operand_stack.sv
// -----------------------------------------------------------------------------
// param_operand_stack
//   Operand stack with call frames, for a stack-machine datapath. One command
//   is executed per cycle in IDLE with priority call > ret > local_set >
//   local_get > push/pop. A call with local_num > 0 enters ALLOC, which
//   zero-fills one local per cycle while ready is low.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   push_en/push_data    push a value (may combine with pop_num)
//   pop_num              number of entries to pop
//   call/para_num/local_num   open a frame over para_num stacked params and
//                        zero-allocate local_num extra locals
//   ret/retu_num         close the frame, optionally returning the top entry
//   local_get/local_set/local_idx   access local[fp + local_idx]
//   ready                high when commands are accepted (IDLE)
//   pop_window           slot k = entry sp-1-k, zero when k >= sp
//   sp, fp, frame_cnt    stack pointer, frame base, open frame count
//   err_*                sticky error flags
// -----------------------------------------------------------------------------
module param_operand_stack #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 64,
    parameter int POP_MAX     = 3,
    parameter int FRAME_DEPTH = 16,
    parameter int LOC_W       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push_en,
    input  logic [WIDTH-1:0]                 push_data,
    input  logic [$clog2(POP_MAX+1)-1:0]     pop_num,
    input  logic                             call,
    input  logic [LOC_W-1:0]                 para_num,
    input  logic [LOC_W-1:0]                 local_num,
    input  logic                             ret,
    input  logic                             retu_num,
    input  logic                             local_get,
    input  logic                             local_set,
    input  logic [LOC_W-1:0]                 local_idx,
    output logic                             ready,
    output logic [POP_MAX*WIDTH-1:0]         pop_window,
    output logic [$clog2(DEPTH):0]           sp,
    output logic [$clog2(DEPTH)-1:0]         fp,
    output logic [$clog2(FRAME_DEPTH):0]     frame_cnt,
    output logic                             err_overflow,
    output logic                             err_underflow,
    output logic                             err_frame,
    output logic                             err_local
);

    localparam int AW   = $clog2(DEPTH);
    localparam int SP_W = AW + 1;
    localparam int FC_W = $clog2(FRAME_DEPTH) + 1;
    localparam int FI_W = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
    localparam int CW   = 32;   // wide enough that range checks never wrap

    typedef enum logic {S_IDLE, S_ALLOC} state_t;

    logic [WIDTH-1:0] mem_q   [DEPTH];
    logic [SP_W-1:0]  frame_q [FRAME_DEPTH];

    state_t           state_q, state_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [SP_W-1:0]  fp_q, fp_d;   // one bit wider than the port: fp may equal DEPTH
    logic [FC_W-1:0]  fc_q, fc_d;
    logic [LOC_W-1:0] alloc_q, alloc_d;
    logic             eov_q, eov_d, eun_q, eun_d, efr_q, efr_d, elo_q, elo_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             fr_push;

    logic [CW-1:0]    sp_w, fp_w, pop_w, push_w, para_w, lnum_w, loc_w;
    logic [WIDTH-1:0] top_val, loc_val;

    assign sp_w   = CW'(sp_q);
    assign fp_w   = CW'(fp_q);
    assign pop_w  = CW'(pop_num);
    assign push_w = CW'(push_en);
    assign para_w = CW'(para_num);
    assign lnum_w = CW'(local_num);
    assign loc_w  = fp_w + CW'(local_idx);

    // Read ports; addresses may be stale when out of range, but such commands
    // are rejected before any write uses the value.
    assign top_val = mem_q[AW'(sp_q - SP_W'(1))];
    assign loc_val = mem_q[AW'(loc_w)];

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        fp_d    = fp_q;
        fc_d    = fc_q;
        alloc_d = alloc_q;
        eov_d   = eov_q;
        eun_d   = eun_q;
        efr_d   = efr_q;
        elo_d   = elo_q;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        fr_push = 1'b0;

        if (state_q == S_ALLOC) begin
            wr_en   = 1'b1;
            wr_addr = AW'(sp_q);
            sp_d    = sp_q + SP_W'(1);
            alloc_d = alloc_q - LOC_W'(1);
            if (alloc_q == LOC_W'(1)) state_d = S_IDLE;
        end else if (call) begin
            if (fc_q == FC_W'(FRAME_DEPTH) || para_w > sp_w) begin
                efr_d = 1'b1;
            end else if (sp_w + lnum_w > CW'(DEPTH)) begin
                eov_d = 1'b1;
            end else begin
                fr_push = 1'b1;
                fp_d    = SP_W'(sp_w - para_w);
                fc_d    = fc_q + FC_W'(1);
                alloc_d = local_num;
                if (local_num != '0) state_d = S_ALLOC;
            end
        end else if (ret) begin
            // sp < fp (caller entries popped) also has no valid result to return
            if (fc_q == '0 || (retu_num && sp_w <= fp_w)) begin
                efr_d = 1'b1;
            end else begin
                if (retu_num) begin
                    wr_en   = 1'b1;
                    wr_addr = AW'(fp_q);
                    wr_data = top_val;
                end
                sp_d = fp_q + SP_W'(retu_num);
                fp_d = frame_q[FI_W'(fc_q - FC_W'(1))];
                fc_d = fc_q - FC_W'(1);
            end
        end else if (local_set) begin
            // fp + idx >= sp also covers sp == fp and sp < fp
            if (loc_w >= sp_w) begin
                elo_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = AW'(loc_w);
                wr_data = top_val;
                sp_d    = sp_q - SP_W'(1);
            end
        end else if (local_get) begin
            if (loc_w >= sp_w) begin
                elo_d = 1'b1;
            end else if (sp_w == CW'(DEPTH)) begin
                eov_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_addr = AW'(sp_q);
                wr_data = loc_val;
                sp_d    = sp_q + SP_W'(1);
            end
        end else if (push_en || pop_num != '0) begin
            if (pop_w > sp_w) begin
                eun_d = 1'b1;
            end else if (sp_w - pop_w + push_w > CW'(DEPTH)) begin
                eov_d = 1'b1;
            end else begin
                sp_d    = SP_W'(sp_w - pop_w + push_w);
                wr_en   = push_en;
                wr_addr = AW'(sp_w - pop_w);
                wr_data = push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            fp_q    <= '0;
            fc_q    <= '0;
            alloc_q <= '0;
            eov_q   <= 1'b0;
            eun_q   <= 1'b0;
            efr_q   <= 1'b0;
            elo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fp_q    <= fp_d;
            fc_q    <= fc_d;
            alloc_q <= alloc_d;
            eov_q   <= eov_d;
            eun_q   <= eun_d;
            efr_q   <= efr_d;
            elo_q   <= elo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (fr_push) frame_q[FI_W'(fc_q)] <= fp_q;
    end

    always_comb begin
        pop_window = '0;
        for (int unsigned k = 0; k < POP_MAX; k++) begin
            if (k < sp_w) pop_window[k*WIDTH +: WIDTH] = mem_q[AW'(sp_w - k - 1)];
        end
    end

    assign ready         = (state_q == S_IDLE);
    assign sp            = sp_q;
    assign fp            = AW'(fp_q);
    assign frame_cnt     = fc_q;
    assign err_overflow  = eov_q;
    assign err_underflow = eun_q;
    assign err_frame     = efr_q;
    assign err_local     = elo_q;

endmodule

// File: tb/tb_param_operand_stack.sv
// -----------------------------------------------------------------------------
// tb_param_operand_stack
//   Directed test of param_operand_stack with DEPTH=8, FRAME_DEPTH=2.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_param_operand_stack;
    localparam int WIDTH = 32, DEPTH = 8, POP_MAX = 3, FRAME_DEPTH = 2, LOC_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_en;
    logic [31:0] push_data;
    logic [1:0]  pop_num;
    logic        call;
    logic [7:0]  para_num, local_num;
    logic        ret, retu_num, local_get, local_set;
    logic [7:0]  local_idx;
    logic        ready;
    logic [95:0] pop_window;
    logic [3:0]  sp;
    logic [2:0]  fp;
    logic [1:0]  frame_cnt;
    logic        err_overflow, err_underflow, err_frame, err_local;
    logic [3:0]  errs;

    int errors = 0;
    int checks = 0;

    assign errs = {err_overflow, err_underflow, err_frame, err_local};

    always #5 clk = ~clk;

    param_operand_stack #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .POP_MAX(POP_MAX),
        .FRAME_DEPTH(FRAME_DEPTH), .LOC_W(LOC_W)
    ) dut (
        .clk(clk), .rst(rst), .push_en(push_en), .push_data(push_data),
        .pop_num(pop_num), .call(call), .para_num(para_num), .local_num(local_num),
        .ret(ret), .retu_num(retu_num), .local_get(local_get), .local_set(local_set),
        .local_idx(local_idx), .ready(ready), .pop_window(pop_window), .sp(sp),
        .fp(fp), .frame_cnt(frame_cnt), .err_overflow(err_overflow),
        .err_underflow(err_underflow), .err_frame(err_frame), .err_local(err_local)
    );

    task automatic clear_in();
        push_en = 0; push_data = '0; pop_num = '0; call = 0; para_num = '0;
        local_num = '0; ret = 0; retu_num = 0; local_get = 0; local_set = 0; local_idx = '0;
    endtask

    task automatic step();
        @(posedge clk); #1; clear_in();
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic do_push(input logic [31:0] d);
        push_en = 1; push_data = d; step();
    endtask

    task automatic do_pop_push(input logic [1:0] n, input logic en, input logic [31:0] d);
        pop_num = n; push_en = en; push_data = d; step();
    endtask

    task automatic do_call(input logic [7:0] p, input logic [7:0] l);
        call = 1; para_num = p; local_num = l; step();
    endtask

    task automatic do_ret(input logic r);
        ret = 1; retu_num = r; step();
    endtask

    task automatic do_lget(input logic [7:0] i);
        local_get = 1; local_idx = i; step();
    endtask

    task automatic do_lset(input logic [7:0] i);
        local_set = 1; local_idx = i; step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sp !== 4'd0) begin errors++; $display("FAIL rst_sp got=%0d exp=0", sp); end
        checks++; if (fp !== 3'd0) begin errors++; $display("FAIL rst_fp got=%0d exp=0", fp); end
        checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL rst_fc got=%0d exp=0", frame_cnt); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
        checks++; if (errs !== 4'b0000) begin errors++; $display("FAIL rst_errs got=%b exp=0000", errs); end
        checks++; if (pop_window !== 96'd0) begin errors++; $display("FAIL rst_win got=%h exp=0", pop_window); end
    endtask

    task automatic test_push_pop();
        do_reset();
        do_push(1); do_push(2); do_push(3);
        checks++; if (sp !== 4'd3) begin errors++; $display("FAIL pp_sp3 got=%0d exp=3", sp); end
        checks++; if (pop_window !== {32'd1, 32'd2, 32'd3}) begin errors++; $display("FAIL pp_win3 got=%h", pop_window); end
        do_pop_push(2, 1, 9);
        checks++; if (sp !== 4'd2) begin errors++; $display("FAIL pp_sp2 got=%0d exp=2", sp); end
        checks++; if (pop_window !== {32'd0, 32'd1, 32'd9}) begin errors++; $display("FAIL pp_win_popush got=%h exp {0,1,9}", pop_window); end
        do_pop_push(1, 0, 0);
        checks++; if (sp !== 4'd1) begin errors++; $display("FAIL pp_sp1 got=%0d exp=1", sp); end
        checks++; if (pop_window !== {32'd0, 32'd0, 32'd1}) begin errors++; $display("FAIL pp_win_pop got=%h", pop_window); end
        checks++; if (errs !== 4'b0000) begin errors++; $display("FAIL pp_errs got=%b exp=0000", errs); end
    endtask

    task automatic test_call_alloc();
        int low;
        do_reset();
        do_push(5); do_push(6);
        do_call(2, 3);
        checks++; if (fp !== 3'd0) begin errors++; $display("FAIL ca_fp got=%0d exp=0", fp); end
        checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL ca_fc got=%0d exp=1", frame_cnt); end
        low = (ready === 1'b0) ? 1 : 0;
        for (int i = 0; i < 10 && ready !== 1'b1; i++) begin
            step();
            if (ready !== 1'b1) low++;
        end
        checks++; if (low !== 3) begin errors++; $display("FAIL ca_ready_low got=%0d cycles exp=3", low); end
        checks++; if (sp !== 4'd5) begin errors++; $display("FAIL ca_sp got=%0d exp=5", sp); end
        checks++; if (pop_window !== 96'd0) begin errors++; $display("FAIL ca_win got=%h exp=0", pop_window); end
        do_push(7);
        checks++; if (sp !== 4'd6) begin errors++; $display("FAIL ca_sp_push got=%0d exp=6", sp); end
        do_ret(1);
        checks++; if (sp !== 4'd1) begin errors++; $display("FAIL ret_sp got=%0d exp=1", sp); end
        checks++; if (fp !== 3'd0) begin errors++; $display("FAIL ret_fp got=%0d exp=0", fp); end
        checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL ret_fc got=%0d exp=0", frame_cnt); end
        checks++; if (pop_window !== {32'd0, 32'd0, 32'd7}) begin errors++; $display("FAIL ret_win got=%h exp {7,0,0}", pop_window); end
        checks++; if (errs !== 4'b0000) begin errors++; $display("FAIL ret_errs got=%b exp=0000", errs); end
    endtask

    task automatic test_locals();
        do_reset();
        do_push(4);
        do_call(1, 0);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lo_ready got=%b exp=1", ready); end
        checks++; if (frame_cnt !== 2'd1) begin errors++; $display("FAIL lo_fc got=%0d exp=1", frame_cnt); end
        do_lget(0);
        checks++; if (pop_window !== {32'd0, 32'd4, 32'd4}) begin errors++; $display("FAIL lo_get_win got=%h", pop_window); end
        do_push(2);
        do_lset(0);
        checks++; if (sp !== 4'd2) begin errors++; $display("FAIL lo_set_sp got=%0d exp=2", sp); end
        checks++; if (pop_window !== {32'd0, 32'd2, 32'd4}) begin errors++; $display("FAIL lo_set_win got=%h exp {4,2,0}", pop_window); end
        checks++; if (errs !== 4'b0000) begin errors++; $display("FAIL lo_errs got=%b exp=0000", errs); end
    endtask

    task automatic test_frame_offset();
        do_reset();
        do_push(10); do_push(20); do_push(30);
        do_call(1, 1);
        step();
        checks++; if (fp !== 3'd2) begin errors++; $display("FAIL fo_fp got=%0d exp=2", fp); end
        checks++; if (sp !== 4'd4) begin errors++; $display("FAIL fo_sp got=%0d exp=4", sp); end
        do_push(77);
        do_lget(3);
        checks++; if (errs !== 4'b0001) begin errors++; $display("FAIL fo_errlocal got=%b exp=0001", errs); end
        checks++; if (sp !== 4'd5) begin errors++; $display("FAIL fo_errlocal_sp got=%0d exp=5", sp); end
        do_lset(1);
        checks++; if (pop_window !== {32'd20, 32'd30, 32'd77}) begin errors++; $display("FAIL fo_set_win got=%h", pop_window); end
        do_ret(1);
        checks++; if (sp !== 4'd3) begin errors++; $display("FAIL fo_ret_sp got=%0d exp=3", sp); end
        checks++; if (pop_window !== {32'd10, 32'd20, 32'd77}) begin errors++; $display("FAIL fo_ret_win got=%h", pop_window); end
    endtask

    task automatic test_errors();
        do_reset();
        do_pop_push(1, 0, 0);
        checks++; if (errs !== 4'b0100) begin errors++; $display("FAIL er_under got=%b exp=0100", errs); end
        checks++; if (sp !== 4'd0) begin errors++; $display("FAIL er_under_sp got=%0d exp=0", sp); end
        for (int i = 1; i <= 8; i++) do_push(i);
        checks++; if (sp !== 4'd8) begin errors++; $display("FAIL er_full_sp got=%0d exp=8", sp); end
        do_push(9);
        checks++; if (errs !== 4'b1100) begin errors++; $display("FAIL er_over got=%b exp=1100", errs); end
        checks++; if (pop_window !== {32'd6, 32'd7, 32'd8}) begin errors++; $display("FAIL er_over_win got=%h", pop_window); end
        do_ret(0);
        checks++; if (errs !== 4'b1110) begin errors++; $display("FAIL er_ret got=%b exp=1110", errs); end
        checks++; if (sp !== 4'd8) begin errors++; $display("FAIL er_ret_sp got=%0d exp=8", sp); end
    endtask

    task automatic test_frame_limits();
        do_reset();
        do_call(1, 0);
        checks++; if (errs !== 4'b0010) begin errors++; $display("FAIL fl_para got=%b exp=0010", errs); end
        checks++; if (frame_cnt !== 2'd0) begin errors++; $display("FAIL fl_para_fc got=%0d exp=0", frame_cnt); end
        do_reset();
        do_call(0, 0); do_call(0, 0);
        checks++; if (frame_cnt !== 2'd2) begin errors++; $display("FAIL fl_two_fc got=%0d exp=2", frame_cnt); end
        do_call(0, 0);
        checks++; if (errs !== 4'b0010) begin errors++; $display("FAIL fl_full got=%b exp=0010", errs); end
        checks++; if (frame_cnt !== 2'd2) begin errors++; $display("FAIL fl_full_fc got=%0d exp=2", frame_cnt); end
        do_reset();
        do_push(1);
        do_call(0, 8);
        checks++; if (errs !== 4'b1000) begin errors++; $display("FAIL fl_alloc_over got=%b exp=1000", errs); end
        checks++; if (ready !== 1'b1 || frame_cnt !== 2'd0) begin errors++; $display("FAIL fl_alloc_ignored got ready=%b fc=%0d exp ready=1 fc=0", ready, frame_cnt); end
    endtask

    task automatic test_priority();
        do_reset();
        do_push(1);
        call = 1; para_num = 1; local_num = 0; push_en = 1; push_data = 99; step();
        checks++; if (frame_cnt !== 2'd1 || sp !== 4'd1) begin errors++; $display("FAIL pr_call got fc=%0d sp=%0d exp fc=1 sp=1", frame_cnt, sp); end
        checks++; if (pop_window !== {32'd0, 32'd0, 32'd1}) begin errors++; $display("FAIL pr_call_win got=%h", pop_window); end
        ret = 1; retu_num = 1; local_get = 1; local_idx = 0; step();
        checks++; if (sp !== 4'd1 || frame_cnt !== 2'd0) begin errors++; $display("FAIL pr_ret got sp=%0d fc=%0d exp sp=1 fc=0", sp, frame_cnt); end
    endtask

    task automatic test_alloc_reset();
        do_reset();
        do_call(0, 4);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ar_ready_low got=%b exp=0", ready); end
        push_en = 1; push_data = 55; step();
        checks++; if (sp !== 4'd1 || errs !== 4'b0000) begin errors++; $display("FAIL ar_ignore got sp=%0d errs=%b exp sp=1 errs=0000", sp, errs); end
        rst = 1; step(); rst = 0;
        checks++; if (sp !== 4'd0) begin errors++; $display("FAIL ar_sp got=%0d exp=0", sp); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ar_ready got=%b exp=1", ready); end
        checks++; if (frame_cnt !== 2'd0 || errs !== 4'b0000) begin errors++; $display("FAIL ar_fc_errs got fc=%0d errs=%b exp 0/0000", frame_cnt, errs); end
        step();
        checks++; if (sp !== 4'd0 || ready !== 1'b1) begin errors++; $display("FAIL ar_stays got sp=%0d ready=%b exp sp=0 ready=1", sp, ready); end
    endtask

    initial begin
        rst = 1;
        clear_in();
        test_reset();
        test_push_pop();
        test_call_alloc();
        test_locals();
        test_frame_offset();
        test_errors();
        test_frame_limits();
        test_priority();
        test_alloc_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
